// File: rtl/muldiv_sequencer_if.sv
// Execute-stage request/response bundle between the pipeline and the M-extension sequencer.
// The pipeline drives the request side and the sequencer drives the stall and result side.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            MulDivE;
    logic [2:0]      MulDivOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallMD;
    logic            BusyMD;
    logic            MulDivDoneE;
    logic [XLEN-1:0] MulDivResultE;

    modport master (
        output MulDivE, MulDivOpE, SrcAE, SrcBE, FlushE,
        input  StallMD, BusyMD, MulDivDoneE, MulDivResultE
    );

    modport slave (
        input  MulDivE, MulDivOpE, SrcAE, SrcBE, FlushE,
        output StallMD, BusyMD, MulDivDoneE, MulDivResultE
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M execute-stage sequencer: iterative radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up applied when the one-cycle result is presented.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   md
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] opnd;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            neg_q;
    logic            neg_r;

    // ---------------- operand decode (used only in IDLE) ----------------
    logic            is_div;
    logic            a_sgn, b_sgn;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    always_comb begin
        is_div = md.MulDivOpE[2];
        if (is_div) begin
            a_sgn = ~md.MulDivOpE[0];
            b_sgn = ~md.MulDivOpE[0];
        end else begin
            a_sgn = (md.MulDivOpE[1:0] != 2'b11);
            b_sgn = ~md.MulDivOpE[1];
        end
        a_neg    = a_sgn & md.SrcAE[XLEN-1];
        b_neg    = b_sgn & md.SrcBE[XLEN-1];
        a_mag    = a_neg ? -md.SrcAE : md.SrcAE;
        b_mag    = b_neg ? -md.SrcBE : md.SrcBE;
        div_zero = is_div & (md.SrcBE == '0);
        div_ovf  = is_div & ~md.MulDivOpE[0]
                 & (md.SrcAE == {1'b1, {(XLEN-1){1'b0}}})
                 & (md.SrcBE == '1);
    end

    // ---------------- one iteration of either datapath ----------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo;
    logic [XLEN:0]   div_shift, div_diff;
    logic [XLEN-1:0] div_hi, div_lo;

    always_comb begin
        // hi:lo is the partial product; the multiplier bit shifts out of lo[0]
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        mul_hi  = mul_sum[XLEN:1];
        mul_lo  = {mul_sum[0], lo[XLEN-1:1]};

        // hi is the partial remainder, lo shifts dividend bits out and quotient bits in
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[XLEN]) begin
            div_hi = div_diff[XLEN-1:0];
            div_lo = {lo[XLEN-2:0], 1'b1};
        end else begin
            div_hi = div_shift[XLEN-1:0];
            div_lo = {lo[XLEN-2:0], 1'b0};
        end
    end

    // ---------------- sequencing ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (md.FlushE) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md.MulDivE) begin
                        op_q <= md.MulDivOpE;
                        cnt  <= CW'(XLEN);
                        if (div_zero) begin
                            lo    <= '1;
                            hi    <= md.SrcAE;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DONE;
                        end else if (div_ovf) begin
                            lo    <= md.SrcAE;
                            hi    <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= is_div ? a_mag : b_mag;
                            opnd  <= is_div ? b_mag : a_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (op_q[2]) begin
                        hi <= div_hi;
                        lo <= div_lo;
                    end else begin
                        hi <= mul_hi;
                        lo <= mul_lo;
                    end
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- result fix-up and outputs ----------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, res;
    logic              done;

    always_comb begin
        prod_s = neg_q ? -{hi, lo} : {hi, lo};
        quo_s  = neg_q ? -lo : lo;
        rem_s  = neg_r ? -hi : hi;
        case (op_q)
            3'b000:                 res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res = quo_s;
            default:                res = rem_s;
        endcase
    end

    // A flush in DONE squashes the result, so the instruction never reaches M.
    assign done             = (state == DONE) & ~md.FlushE;
    assign md.MulDivDoneE   = done;
    assign md.MulDivResultE = done ? res : '0;
    assign md.BusyMD        = (state != IDLE);
    assign md.StallMD       = rst & ~md.FlushE
                            & (((state == IDLE) & md.MulDivE) | (state == RUN));
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, flush, async reset and
// randomized ops checked against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_sequencer_if #(.XLEN(32)) md();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0];  end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 right after the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [31:0] exp, got;
        int  stalls, cyc;
        bit  done, stall_in_done;
        exp = ref_model(op, a, b);
        md.MulDivE = 1'b1; md.MulDivOpE = op; md.SrcAE = a; md.SrcBE = b;
        stalls = 0; cyc = 0; done = 0; stall_in_done = 0; got = '0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (md.MulDivDoneE === 1'b1) begin
                done = 1;
                got = md.MulDivResultE;
                stall_in_done = (md.StallMD !== 1'b0);
            end else begin
                if (md.StallMD === 1'b1) stalls++;
                if (md.BusyMD === 1'b1) begin
                    md.SrcAE = $urandom;
                    md.SrcBE = $urandom;
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no MulDivDoneE within %0d cycles", name, cyc);
        end else if (got !== exp) begin
            errors++;
            $display("FAIL %s result: got %h expected %h (op %0d a %h b %h)", name, got, exp, op, a, b);
        end
        checks++;
        if (stalls != ref_stalls(op, a, b) || stall_in_done) begin
            errors++;
            $display("FAIL %s stall: got %0d cycles (stall in done %0d) expected %0d",
                     name, stalls, stall_in_done, ref_stalls(op, a, b));
        end
        @(posedge clk); #1;
        md.MulDivE = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (md.BusyMD !== 1'b0 || md.MulDivDoneE !== 1'b0 || md.StallMD !== 1'b0
            || md.MulDivResultE !== 32'd0) begin
            errors++;
            $display("FAIL %s idle: busy %b done %b stall %b result %h expected all 0",
                     name, md.BusyMD, md.MulDivDoneE, md.StallMD, md.MulDivResultE);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        md.MulDivE = 1'b1; md.MulDivOpE = 3'd0; md.SrcAE = 32'd7; md.SrcBE = 32'd6;
        md.FlushE = 1'b0;
        #13;
        checks++;
        if (md.BusyMD !== 1'b0 || md.MulDivDoneE !== 1'b0 || md.StallMD !== 1'b0
            || md.MulDivResultE !== 32'd0) begin
            errors++;
            $display("FAIL reset outputs: busy %b done %b stall %b result %h expected all 0",
                     md.BusyMD, md.MulDivDoneE, md.StallMD, md.MulDivResultE);
        end
        md.MulDivE = 1'b0;
        #4 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        run_op(3'd0, 32'd7, 32'd6, "mul_7x6");
        check_idle("mul_7x6_after");
        @(posedge clk); #1;
    endtask

    task automatic test_signs();
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_m1");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1");
    endtask

    task automatic test_div();
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, "divu_big_2");
    endtask

    task automatic test_div_special();
        run_op(3'd5, 32'd5, 32'd0, "divu_by0");
        run_op(3'd7, 32'd5, 32'd0, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
    endtask

    task automatic test_flush();
        int  run_cycles, cyc;
        bit  done_seen;
        md.MulDivE = 1'b1; md.MulDivOpE = 3'd0; md.SrcAE = $urandom; md.SrcBE = $urandom;
        run_cycles = 0; cyc = 0;
        while (run_cycles < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (md.BusyMD === 1'b1) run_cycles++;
        end
        md.FlushE = 1'b1;
        #1;
        checks++;
        if (md.StallMD !== 1'b0 || md.MulDivDoneE !== 1'b0 || run_cycles != 10) begin
            errors++;
            $display("FAIL flush cycle: stall %b done %b run cycles %0d expected 0 0 10",
                     md.StallMD, md.MulDivDoneE, run_cycles);
        end
        @(posedge clk); #1;
        md.FlushE = 1'b0;
        md.MulDivE = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md.MulDivDoneE !== 1'b0 || md.BusyMD !== 1'b0) done_seen = 1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL flush after: busy or done seen %0d expected 0", done_seen);
        end
        @(posedge clk); #1;
        run_op(3'd0, 32'd3, 32'd3, "mul_3x3_after_flush");
    endtask

    task automatic test_async_reset();
        md.MulDivE = 1'b1; md.MulDivOpE = 3'd5; md.SrcAE = 32'd1000; md.SrcBE = 32'd3;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (md.BusyMD !== 1'b0 || md.MulDivDoneE !== 1'b0 || md.StallMD !== 1'b0
            || md.MulDivResultE !== 32'd0) begin
            errors++;
            $display("FAIL async reset: busy %b done %b stall %b result %h expected all 0",
                     md.BusyMD, md.MulDivDoneE, md.StallMD, md.MulDivResultE);
        end
        @(posedge clk); #1;
        md.MulDivE = 1'b0;
        #2 rst = 1'b1;
        check_idle("after_reset");
        @(posedge clk); #1;
        run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
    endtask

    task automatic test_back_to_back();
        run_op(3'd3, $urandom, $urandom, "b2b_mulhu");
        run_op(3'd6, $urandom, $urandom_range(1, 255), "b2b_rem");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "b2b_div_ovf");
        run_op(3'd0, $urandom, $urandom, "b2b_mul");
        check_idle("b2b_after");
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 32; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        errors = 0;
        test_reset();
        test_mul_basic();
        test_signs();
        test_div();
        test_div_special();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Execute-stage controller for RV32M MUL/DIV instructions: sequences an iterative radix-2 shift-add multiplier and restoring divider.
- Stalls the F/D/E pipeline registers while the operation runs, then presents a one-cycle result alongside the ALU result in execute.
- Sits beside the ALU inside the execute cycle. The hazard unit ORs StallMD into its stall outputs.

Parameters:
- XLEN, 32, operand/result width; iteration count of the multiply and divide loops.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- MulDivE  input  1  the instruction in E is an M-extension op (valid request).
- MulDivOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  input  XLEN  rs1 operand after forwarding.
- SrcBE  input  XLEN  rs2 operand after forwarding.
- FlushE  input  1  squash the instruction in E (branch taken / exception).
- StallMD  output  1  freeze the PC and the F/D/E registers, and insert a bubble into M.
- BusyMD  output  1  FSM is not IDLE.
- MulDivDoneE  output  1  result valid this cycle; the instruction advances to M on the next edge.
- MulDivResultE  output  XLEN  result, valid only while MulDivDoneE=1, otherwise 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - Operand and accumulator registers clear.
  - All outputs are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If MulDivE=1 and FlushE=0, StallMD=1 combinationally in the same cycle.
  - Operand magnitudes and sign flags latch at the edge; the counter loads XLEN.
  - Next state is RUN, except for division special cases, which go directly to DONE.
- RUN:
  - StallMD=1, BusyMD=1.
  - One iteration per cycle; the counter decrements.
  - When the counter reaches 1, the next state is DONE.
  - RUN lasts exactly XLEN cycles.
- DONE:
  - StallMD=0, MulDivDoneE=1, and MulDivResultE is driven.
  - Next state is IDLE unconditionally.
  - MulDivE is still high in DONE (same instruction); DONE must not restart the operation.
- Latency:
  - Normal op: StallMD is high for XLEN+1 cycles and the instruction occupies E for XLEN+2 cycles.
  - Special-case division: 1 stall cycle, then DONE.
- FlushE=1 in any state:
  - Next state is IDLE and no MulDivDoneE is produced.
  - StallMD is deasserted in the flush cycle.
  - FlushE takes priority over a start in IDLE.
- Multiply:
  - Unsigned XLEN×XLEN shift-add on magnitudes, giving a 2·XLEN product.
  - The product is negated if the operand signs differ.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU treats both as unsigned.
  - MUL returns the low XLEN bits; the other three return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes. The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU/REMU are unsigned.
- Divide special cases (decided in IDLE, no RUN):
  - Divisor 0: quotient is all ones; remainder is the dividend.
  - Signed DIV/REM with A=0x80000000 and B=0xFFFFFFFF: quotient is 0x80000000; remainder is 0.
- Operands are captured only in IDLE; SrcAE/SrcBE changes during RUN are ignored.
- A back-to-back M-op enters E after DONE and starts from IDLE on the next cycle. There is no zero-cycle reuse.

Test Plan:
- MUL 7×6: StallMD high for 33 cycles, then MulDivDoneE=1 with MulDivResultE=0x0000002A for exactly one cycle; StallMD=0 in that cycle.
- Sign handling with A=B=0xFFFFFFFF: MULH gives 0x00000000, MULHU gives 0xFFFFFFFE, MULHSU gives 0xFFFFFFFF, MUL gives 0x00000001.
- DIV −7/2: result 0xFFFFFFFD. REM −7/2: result 0xFFFFFFFF. DIVU 0xFFFFFFF9/2: result 0x7FFFFFFC.
- DIVU 5/0: result 0xFFFFFFFF with one stall cycle. REMU 5/0: result 5. DIV 0x80000000/0xFFFFFFFF: result 0x80000000. REM of the same operands: result 0. All complete with one stall cycle.
- FlushE pulsed on RUN cycle 10: next state IDLE, StallMD low, no MulDivDoneE. A following MUL 3×3 returns 9 with full latency.
- rst pulled low mid-RUN (asynchronously, between edges): outputs drop to 0 immediately; after release, a new DIVU 100/7 returns 14 and REMU 100/7 returns 2.
